// File: rtl/fft_pkg.sv
// Shared types and constants for the 2048-point FFT frame loader and its bank sub-blocks.
package fft_pkg;

  localparam int FFT_POINTS    = 2048;
  localparam int FFT_AW        = 11;
  localparam int FFT_BANKS     = 8;
  localparam int FFT_BANK_SIZE = 256;
  localparam int FFT_ROWS      = 16;

  typedef logic [FFT_AW-1:0] fft_addr_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } fft_demux_state_e;

  // Mirror the address bits so natural-order input lands in DIT bit-reversed order.
  function automatic fft_addr_t fft_bitrev(input fft_addr_t addr);
    fft_addr_t rev;
    for (int i = 0; i < FFT_AW; i++) begin
      rev[i] = addr[FFT_AW-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_demux_1x256_bank.sv
// One 256-entry slice of the frame register file; writes the entry selected by row enable and column.
module fft_demux_1x256_bank #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bank_en,
  input  logic [15:0]           row_en,
  input  logic [3:0]            col,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] data [256]
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        data[i] <= '0;
      end
    end else if (bank_en) begin
      for (int r = 0; r < 16; r++) begin
        if (row_en[r]) begin
          data[{r[3:0], col}] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/fft_demux_1x2048.sv
// Serial-to-parallel frame loader for the 2048-point FFT with a 3-stage write pipeline.
// Define FFT_DEMUX_BITREV_EN to store samples at bit-reversed addresses.
module fft_demux_1x2048
  import fft_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_POINTS = 2048,
  localparam int AW         = $clog2(NUM_POINTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [DATA_WIDTH-1:0] data_o [NUM_POINTS],
  output logic [AW:0]           load_cnt
);

  fft_demux_state_e state, next_state;

  logic            take;
  logic            last_take;
  fft_addr_t       wr_addr;

  logic            s1_valid;
  logic            s1_last;
  fft_addr_t       s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;

  logic            s2_valid;
  logic            s2_last;
  logic [FFT_BANKS-1:0] s2_bank_en;
  logic [FFT_ROWS-1:0]  s2_row_en;
  logic [3:0]      s2_col;
  logic [DATA_WIDTH-1:0] s2_data;

  logic [DATA_WIDTH-1:0] bank_data [FFT_BANKS][FFT_BANK_SIZE];

  // flush has priority over an accept in the same cycle
  assign take      = in_valid & in_ready & ~flush;
  assign last_take = take & (load_cnt == (AW+1)'(NUM_POINTS-1));

`ifdef FFT_DEMUX_BITREV_EN
  assign wr_addr = fft_bitrev(load_cnt[AW-1:0]);
`else
  assign wr_addr = load_cnt[AW-1:0];
`endif

  assign frame_valid = (state == FULL);

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (last_take) next_state = DRAIN;
      DRAIN:   if (s2_valid && s2_last) next_state = FULL;
      FULL:    if (frame_ready) next_state = LOAD;
      default: next_state = LOAD;
    endcase
    if (flush) next_state = LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == LOAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
    end else if (flush || (state == FULL && frame_ready)) begin
      load_cnt <= '0;
    end else if (take) begin
      load_cnt <= load_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= take;
      s1_last  <= last_take;
      s1_addr  <= wr_addr;
      s1_data  <= in_data;
    end
  end

  // Decode stage: top address bits pick the bank, middle bits pick the row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_bank_en <= '0;
      s2_row_en  <= '0;
      s2_col     <= '0;
      s2_data    <= '0;
    end else begin
      s2_valid   <= s1_valid & ~flush;
      s2_last    <= s1_valid & s1_last & ~flush;
      s2_bank_en <= (s1_valid && !flush) ? (FFT_BANKS'(1) << s1_addr[10:8]) : '0;
      s2_row_en  <= FFT_ROWS'(1) << s1_addr[7:4];
      s2_col     <= s1_addr[3:0];
      s2_data    <= s1_data;
    end
  end

  for (genvar b = 0; b < FFT_BANKS; b++) begin : g_bank
    fft_demux_1x256_bank #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .bank_en(s2_bank_en[b] & ~flush),
      .row_en (s2_row_en),
      .col    (s2_col),
      .wdata  (s2_data),
      .data   (bank_data[b])
    );
  end

  for (genvar i = 0; i < NUM_POINTS; i++) begin : g_out
    assign data_o[i] = bank_data[i / FFT_BANK_SIZE][i % FFT_BANK_SIZE];
  end

endmodule
